uart_tx_fifo: RTL

//   8N1 UART transmitter with a small write FIFO. It drives the receive pin of a

---
 rtl/uart_tx_fifo.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO.
// Bytes go out LSB-first. Each bit lasts prescale+1 clocks, using the prescale
// value latched when the byte is popped from the FIFO.
module uart_tx_fifo #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned PRE_W   = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             en,
  input  logic [PRE_W-1:0] prescale,
  input  logic             wr,
  input  logic [7:0]       wdata,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic             tx_done,
  output logic             tx
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CNT_W = FIFO_AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_n;
  logic               wr_acc;
  logic               pop;

  logic [1:0]         state;
  logic [1:0]         state_n;
  logic [PRE_W-1:0]   bit_cnt;
  logic [PRE_W-1:0]   bit_cnt_n;
  logic [PRE_W-1:0]   period;
  logic [PRE_W-1:0]   period_n;
  logic [7:0]         shift;
  logic [7:0]         shift_n;
  logic [2:0]         bit_idx;
  logic [2:0]         bit_idx_n;
  logic               bit_end;
  logic               tx_n;
  logic               busy_n;
  logic               tx_done_n;

  // A write is dropped whenever the FIFO is full, even if a pop happens in the same cycle.
  assign wr_acc = wr & ~full;

  // Occupancy after this cycle's write and pop.
  always_comb begin
    count_n = count + CNT_W'(wr_acc) - CNT_W'(pop);
  end

  // FIFO storage. It holds no reset value; the read side only uses entries that were written.
  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // FIFO pointers, count, and the registered full/empty flags.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      count <= count_n;
      full  <= (count_n == CNT_W'(DEPTH));
      empty <= (count_n == '0);
    end
  end

  // FSM state and registered datapath and outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      period  <= '0;
      shift   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      period  <= period_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      tx      <= tx_n;
      busy    <= busy_n;
      tx_done <= tx_done_n;
    end
  end

  // Next-state logic. Outputs are decoded from the next state so that they line up with it after the edge.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    period_n  = period;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    pop       = 1'b0;
    bit_end   = (bit_cnt == '0);

    case (state)
      S_IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          shift_n   = mem[rd_ptr];
          period_n  = prescale;
          bit_cnt_n = prescale;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_n   = S_DATA;
          bit_idx_n = 3'd0;
          bit_cnt_n = period;
        end else begin
          bit_cnt_n = bit_cnt - PRE_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bit_cnt_n = period;
          shift_n   = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt - PRE_W'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (en && !empty) begin
            pop       = 1'b1;
            shift_n   = mem[rd_ptr];
            period_n  = prescale;
            bit_cnt_n = prescale;
            state_n   = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt - PRE_W'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    tx_n = 1'b1;
    case (state_n)
      S_START: tx_n = 1'b0;
      S_DATA:  tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
    busy_n    = (state_n != S_IDLE);
    tx_done_n = (state_n == S_STOP) && (bit_cnt_n == '0);
  end

endmodule
